// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR stream sequencer.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 65;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_e;

  // Per-input tag: real input, sample comes from RAM, final input of pass.
  typedef struct packed {
    logic valid;
    logic ram;
    logic last;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/fir_tag_pipe.sv
// Enable-gated shift register carrying per-input tags alongside the filter.
module fir_tag_pipe #(
  parameter int W     = 3,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] tail_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head_o = stage_q[0];
  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fir_stream_ctrl.sv
// Sequences one FIR pass: RAM samples then zero flush, results on a
// valid/ready stream with the filter stalled under back-pressure.
module fir_stream_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_W      = fir_pkg::DATA_W,
  parameter int OUT_W       = fir_pkg::OUT_W,
  parameter int ADDR_W      = fir_pkg::ADDR_W,
  parameter int NUM_SAMPLES = 200,
  parameter int FLUSH_LEN   = 16,
  parameter int FIR_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fir_en,
  output logic [DATA_W-1:0] fir_in,
  input  logic [OUT_W-1:0]  fir_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_last
);

  localparam int FCW = $clog2(FLUSH_LEN + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [FCW-1:0]    LAST_FLUSH = FCW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FCW-1:0]    flush_q, flush_d;
  logic              res_valid_q, res_valid_d;
  logic              res_last_q, res_last_d;
  logic [OUT_W-1:0]  res_data_q, res_data_d;

  logic en;
  tag_t tag_in, tag_head, tag_tail;

  assign en = busy_q & ~(res_valid_q & ~res_ready);

  // Head stage doubles as the input tag selecting RAM data vs zero;
  // the tail lines up with fir_out FIR_LAT enabled cycles later.
  fir_tag_pipe #(
    .W     (TAG_W),
    .DEPTH (FIR_LAT + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .d_i    (tag_in),
    .head_o (tag_head),
    .tail_o (tag_tail)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    flush_d = flush_q;
    tag_in  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          busy_d  = 1'b1;
          addr_d  = '0;
          flush_d = '0;
        end
      end
      FEED: begin
        if (en) begin
          tag_in.valid = 1'b1;
          tag_in.ram   = 1'b1;
          addr_d       = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            tag_in.last = (FLUSH_LEN == 0);
            state_d     = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
          end
        end
      end
      FLUSH: begin
        if (en) begin
          tag_in.valid = 1'b1;
          flush_d      = flush_q + 1'b1;
          if (flush_q == LAST_FLUSH) begin
            tag_in.last = 1'b1;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (res_valid_q && res_ready && res_last_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture may coincide with a handshake: en is high then, so the
  // register is simply overwritten.
  always_comb begin
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    res_data_d  = res_data_q;
    if (en) begin
      res_valid_d = tag_tail.valid;
      res_last_d  = tag_tail.valid & tag_tail.last;
      if (tag_tail.valid) res_data_d = fir_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      flush_q     <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      flush_q     <= flush_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fir_en    = en;
  assign mem_rd_en = en & (state_q == FEED);
  assign mem_addr  = addr_q;
  assign fir_in    = tag_head.ram ? mem_rdata : '0;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Sequencer that runs one filtering pass of the FIR datapath (`filter_demo`: 16-bit signed sample in, 65-bit signed result out, one sample per clock). On `start` it streams `NUM_SAMPLES` samples from a synchronous sample RAM into the filter, then `FLUSH_LEN` zero samples to drain the tap line. It returns every filter result on a valid/ready output stream and stalls the filter through its clock enable when the consumer back-pressures. It sits between the sample RAM, the filter and the result sink, replacing the free-running bench feeder.

## Interface
Parameters:
- `DATA_W`, 16: sample width, signed.
- `OUT_W`, 65: filter result width, signed.
- `ADDR_W`, 8: sample RAM address width.
- `NUM_SAMPLES`, 200: samples per pass; 1..2^ADDR_W.
- `FLUSH_LEN`, 16: zero samples appended (filter tap count); 0 allowed.
- `FIR_LAT`, 2: filter latency in enabled cycles, input to `fir_out`; ≥1.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: pass request; sampled only in IDLE.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last result handshake.
- `mem_rd_en` out 1: RAM read strobe.
- `mem_addr` out ADDR_W: RAM read address.
- `mem_rdata` in DATA_W: RAM data. It is valid the cycle after `mem_rd_en`, and the RAM holds it while `mem_rd_en`=0.
- `fir_en` out 1: filter clock enable; filter state advances only when high.
- `fir_in` out DATA_W: filter sample input.
- `fir_out` in OUT_W: filter result.
- `res_valid` out 1: result available.
- `res_ready` in 1: sink accepts.
- `res_data` out OUT_W: registered result.
- `res_last` out 1: qualifies final result of pass.

## Operation
- FSM states:
  - IDLE: `start`=1 goes to FEED, clears counters and raises `busy`.
  - FEED: reads RAM addresses 0..NUM_SAMPLES-1, one per enabled cycle. After the last read it goes to FLUSH, or to DRAIN if FLUSH_LEN=0.
  - FLUSH: presents FLUSH_LEN zero samples.
  - DRAIN: waits for the outstanding results.
  - DONE: single cycle; pulses `done`, drops `busy`, returns to IDLE.
- Total inputs per pass T = NUM_SAMPLES+FLUSH_LEN. Exactly T results are emitted, in input order. Result k is captured from `fir_out` FIR_LAT enabled cycles after input k was presented.
- Stall rule: `fir_en` = `busy` & !(`res_valid` & !`res_ready`). Address counter, flush counter, input tag and valid-tag pipeline all advance only when `fir_en`=1.
- `mem_rd_en` = `fir_en` in FEED.
- `fir_in` is `mem_rdata` when the input tag says RAM sample, and 0 otherwise (flush or idle).
- Valid-tag shift register is FIR_LAT+1 deep and also carries a last flag. Its tail loads `res_data`/`res_valid`/`res_last` on enabled cycles.
- `res_valid`, once high, holds `res_data` and `res_last` stable until `res_ready`=1.
- Result arithmetic: `fir_out` passes through unmodified at full OUT_W, with no truncation or saturation.
- `start` while `busy` is ignored; it is not queued.

## Timing
- Reset values: `busy` 0, `done` 0, `mem_rd_en` 0, `mem_addr` 0, `fir_en` 0, `fir_in` 0, `res_valid` 0, `res_data` 0, `res_last` 0; FSM in IDLE. Reset mid-pass aborts immediately; there is no `done` and no partial results after the reset cycle.
- Cycle 0 is the `start` cycle.
  - Cycle 1: FEED, `mem_addr`=0, `mem_rd_en`=1.
  - Cycle 2: `fir_in`=sample0.
  - First `res_valid` at cycle 2+FIR_LAT+1 with no stall.
- Unstalled pass length: `done` at cycle T+FIR_LAT+4.
- `res_ready` low for S cycles with `res_valid` high freezes filter and RAM. Pass length grows by exactly S.
- `res_last`=1 only on result T-1.
- A result handshake and a new capture in the same cycle are allowed: the register is overwritten with no bubble.
- NUM_SAMPLES=2^ADDR_W: address wraps to 0 only after the pass. No extra read is issued.

## Structure
- Shared package `fir_pkg`: DATA_W, OUT_W, ADDR_W constants and the FSM state enum (IDLE, FEED, FLUSH, DRAIN, DONE).
- One sub-module: `fir_tag_pipe`, a parameterised FIR_LAT+1 enable-gated shift register for the valid/last tags.

## Test plan
- NUM_SAMPLES=4, FLUSH_LEN=2, pass-through filter stub, RAM = {1,2,3,4}, `res_ready`=1 -> results 1,2,3,4,0,0; `res_last` on the 6th; `done` at cycle 6+FIR_LAT+4.
- Same setup, `res_ready` low for 3 cycles while the 2nd result is valid -> `res_data`=2 held, `fir_en`=0 for those 3 cycles, same result sequence, `done` 3 cycles later.
- Real 3-tap filter {1,1,1}, RAM impulse {0x0001,0,0,0}, FLUSH_LEN=3 -> results 1,1,1,0,0,0,0.
- RAM {0x7FFF,0x8000} -> full-width sign-correct results, with no truncation versus the golden model.
- `rst` asserted in cycle 5 of a pass -> all outputs at reset values next cycle, no `done`; a new `start` runs a clean pass.
- `start` pulsed mid-pass -> ignored; exactly one `done` per accepted `start`.
